// File: rtl/counter_pkg.sv
// ============================================================================
// Module      : counter_pkg
// Description : Shared constants and helpers for the up/down modulus counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int clog2(input longint unsigned value);
        longint unsigned v;
        int              r;
        v = (value > 64'd0) ? value - 64'd1 : 64'd0;
        r = 0;
        while (v != 64'd0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Divides enabled cycles by PRESCALE and emits a step tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int                 c_cnt_w = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(PRESCALE - 1);

    logic [c_cnt_w-1:0] r_phase;
    logic               w_phase_end;

    // With PRESCALE=1 the phase is pinned at 0 == c_last, so tick reduces to en.
    assign w_phase_end = (r_phase == c_last);
    assign tick        = en & w_phase_end;

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            r_phase <= '0;
        end else if (en) begin
            if (w_phase_end) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/updown_mod_counter.sv
// ============================================================================
// Module      : updown_mod_counter
// Description : Prescaled up/down modulus counter with wrap or saturate bounds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter int              PRESCALE = 1,
    parameter int              SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] c_max      = WIDTH'(MODULUS - 64'd1);
    localparam bit               c_sat_mode = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_sat;
    logic             w_tick;
    logic             w_restart;
    logic             w_at_bound;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_restart = clear | load;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .restart (w_restart),
        .tick    (w_tick)
    );

    assign w_at_bound     = up ? (r_count == c_max) : (r_count == '0);
    assign tc             = w_tick & w_at_bound;
    assign w_load_clamped = (64'(load_val) >= MODULUS) ? c_max : load_val;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_sat   <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped;
            r_wrap  <= 1'b0;
            r_sat   <= 1'b0;
        end else if (w_tick) begin
            r_wrap <= 1'b0;
            if (w_at_bound) begin
                // Blocked step keeps sat asserted; a wrapping step pulses wrap.
                if (c_sat_mode) begin
                    r_sat <= 1'b1;
                end else begin
                    r_count <= up ? '0 : c_max;
                    r_wrap  <= 1'b1;
                end
            end else begin
                r_count <= up ? r_count + 1'b1 : r_count - 1'b1;
                r_sat   <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign sat   = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
// ============================================================================
// Module      : tb_updown_mod_counter
// Description : Randomised and directed checks of four counter configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_mod_counter;

    localparam int N = 4;

    // Per-instance configuration: a wrap/p1, b sat/p3, c wrap 8-bit, d sat/p1
    int c_wid [N] = '{4, 4, 8, 4};
    int c_mod [N] = '{10, 10, 256, 10};
    int c_pre [N] = '{1, 3, 1, 1};
    int c_sat [N] = '{0, 1, 0, 1};

    logic       clk = 1'b0;
    logic       rst_n, en, up, clear, load;
    logic [7:0] load_val;

    logic [3:0] count_a, count_b, count_d;
    logic [7:0] count_c;
    logic       tc_a, tc_b, tc_c, tc_d;
    logic       wrap_a, wrap_b, wrap_c, wrap_d;
    logic       sat_a, sat_b, sat_c, sat_d;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  model_valid = 1'b0;
    int  m_cnt [N];
    int  m_ph  [N];
    bit  m_wr  [N];
    bit  m_st  [N];

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .count(count_a), .tc(tc_a), .wrap(wrap_a), .sat(sat_a));
    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .count(count_b), .tc(tc_b), .wrap(wrap_b), .sat(sat_b));
    updown_mod_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(1), .SATURATE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .count(count_c), .tc(tc_c), .wrap(wrap_c), .sat(sat_c));
    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .count(count_d), .tc(tc_d), .wrap(wrap_d), .sat(sat_d));

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] obs_count(input int i);
        case (i)
            0:       return 64'(count_a);
            1:       return 64'(count_b);
            2:       return 64'(count_c);
            default: return 64'(count_d);
        endcase
    endfunction

    function automatic logic [2:0] obs_flags(input int i);   // {tc, wrap, sat}
        case (i)
            0:       return {tc_a, wrap_a, sat_a};
            1:       return {tc_b, wrap_b, sat_b};
            2:       return {tc_c, wrap_c, sat_c};
            default: return {tc_d, wrap_d, sat_d};
        endcase
    endfunction

    // Reference: applies one clock edge of the counter rules to every instance.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            int lv;
            lv = int'(load_val) & ((1 << c_wid[i]) - 1);
            if (!rst_n || clear) begin
                m_cnt[i] = 0; m_ph[i] = 0; m_wr[i] = 1'b0; m_st[i] = 1'b0;
            end else if (load) begin
                m_cnt[i] = (lv >= c_mod[i]) ? c_mod[i] - 1 : lv;
                m_ph[i]  = 0; m_wr[i] = 1'b0; m_st[i] = 1'b0;
            end else if (en) begin
                m_wr[i] = 1'b0;
                if (m_ph[i] == c_pre[i] - 1) begin
                    m_ph[i] = 0;
                    if (up && m_cnt[i] < c_mod[i] - 1) begin
                        m_cnt[i]++; m_st[i] = 1'b0;
                    end else if (!up && m_cnt[i] > 0) begin
                        m_cnt[i]--; m_st[i] = 1'b0;
                    end else if (c_sat[i] != 0) begin
                        m_st[i] = 1'b1;
                    end else begin
                        m_cnt[i] = up ? 0 : c_mod[i] - 1;
                        m_wr[i]  = 1'b1;
                    end
                end else begin
                    m_ph[i]++;
                end
            end else begin
                m_wr[i] = 1'b0;
            end
        end
        if (!rst_n) model_valid = 1'b1;
    endtask

    task automatic cycle();
        logic [2:0] f;
        bit         exp_tc;
        #1;
        if (model_valid) begin
            for (int i = 0; i < N; i++) begin
                exp_tc = en && (m_ph[i] == c_pre[i] - 1) &&
                         (up ? (m_cnt[i] == c_mod[i] - 1) : (m_cnt[i] == 0));
                f = obs_flags(i);
                check_eq($sformatf("tc[%0d]", i), 64'(f[2]), 64'(exp_tc));
            end
        end
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            f = obs_flags(i);
            check_eq($sformatf("count[%0d]", i), obs_count(i), 64'(m_cnt[i]));
            check_eq($sformatf("wrap[%0d]", i), 64'(f[1]), 64'(m_wr[i]));
            check_eq($sformatf("sat[%0d]", i), 64'(f[0]), 64'(m_st[i]));
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit e, input bit u, input bit c, input bit l,
                         input logic [7:0] lv, input int n);
        rst_n = r; en = e; up = u; clear = c; load = l; load_val = lv;
        for (int k = 0; k < n; k++) cycle();
    endtask

    logic [7:0] lv_table [6] = '{8'd0, 8'd9, 8'd10, 8'd15, 8'd254, 8'd255};

    initial begin
        //    rst en up clr ld  val  cycles
        drive(0, 0, 1, 0, 0, 8'd0,   2);   // reset state
        drive(1, 1, 1, 0, 0, 8'd0,  12);   // up count and wrap
        drive(1, 1, 1, 0, 1, 8'd2,   1);   // load beats step
        drive(1, 1, 0, 0, 0, 8'd0,   4);   // down into lower bound
        drive(1, 1, 1, 0, 0, 8'd0,   3);   // direction change releases sat
        drive(1, 0, 1, 0, 1, 8'd15,  1);   // load clamp
        drive(1, 0, 1, 1, 1, 8'd5,   1);   // clear beats load
        drive(1, 1, 1, 0, 0, 8'd0,   4);
        drive(1, 0, 1, 0, 0, 8'd0,   2);   // en low freezes phase
        drive(1, 1, 1, 0, 0, 8'd0,   5);
        drive(1, 0, 1, 0, 1, 8'd7,   1);
        drive(1, 1, 1, 0, 0, 8'd0,   1);   // mid-phase
        drive(0, 1, 1, 0, 0, 8'd0,   1);   // reset wins
        drive(1, 1, 1, 0, 0, 8'd0,   4);
        drive(1, 1, 1, 0, 1, 8'd255, 1);   // full-range bounds
        drive(1, 1, 1, 0, 0, 8'd0,   2);
        drive(1, 1, 0, 0, 1, 8'd0,   1);
        drive(1, 1, 0, 0, 0, 8'd0,   2);

        for (int k = 0; k < 800; k++) begin
            rst_n    = ($urandom_range(0, 59) != 0);
            clear    = ($urandom_range(0, 24) == 0);
            load     = ($urandom_range(0, 14) == 0);
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 6) == 0) up = ~up;
            load_val = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                                   : lv_table[$urandom_range(0, 5)];
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
